scan_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder. Successor to the combinational 2-to-4 and 3-to-8 decoders, adding a sequential channel scanner. Two modes:
- Direct: the decoder holds a loaded select value.
- Scan: an internal index steps through all 2^N channels, dwelling DWELL cycles on each.
Used to drive channel/row strobes (display digit scan, bank enables) from a single clock domain.

---
 rtl/scan_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Registered N-to-2^N one-hot decoder with a built-in channel scanner.
//
// Two modes share one channel index:
//   * direct (i_mode = 0): the index holds whatever value was last loaded.
//   * scan   (i_mode = 1): the index steps through all 2^N channels and
//                          dwells DWELL enabled cycles on each one.
// A load strobe always captures i_sel into the index and restarts the dwell.
// The decoded strobe follows the index on the same edge and is blanked
// whenever i_en is low.
//
// Every output is a flop. Inputs reach the outputs only through the
// registers, so there is no combinational path from inputs to outputs.
//
// Parameters:
//   N      select width, 1..6; the decoder drives 2^N channel strobes
//   DWELL  cycles spent on each channel in scan mode, >= 1
//
// Ports:
//   i_clk   clock; all state changes on the rising edge
//   i_rst   synchronous active-high reset; overrides every other input
//   i_en    output enable and scan run; blanks o_d and pauses scan when low
//   i_mode  0 = direct, 1 = scan
//   i_load  single-cycle strobe that captures i_sel into the index
//   i_sel   select value captured on i_load
//   o_d     registered one-hot channel strobe (all-zero when disabled)
//   o_idx   registered current channel index
//   o_wrap  registered one-cycle pulse when the scan steps 2^N-1 -> 0
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_mode,
    input  logic                i_load,
    input  logic [N-1:0]        i_sel,
    output logic [(1<<N)-1:0]   o_d,
    output logic [N-1:0]        o_idx,
    output logic                o_wrap
);

    // Number of channel strobes.
    localparam int NCH = 1 << N;

    // Dwell counter width. A single flop is kept even when DWELL is 1 so
    // the datapath has one shape; with DWELL = 1 it simply stays at zero.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]   IDX_ONE  = N'(1);
    localparam logic [N-1:0]   IDX_LAST = {N{1'b1}};
    localparam logic [NCH-1:0] D_ZERO   = {NCH{1'b0}};
    localparam logic [NCH-1:0] D_LSB    = NCH'(1);

    // State registers.
    logic [N-1:0]   r_idx;
    logic [CW-1:0]  r_cnt;
    logic [NCH-1:0] r_d;
    logic           r_wrap;

    // Next-state values.
    logic [N-1:0]   w_idx_next;
    logic [CW-1:0]  w_cnt_next;
    logic [NCH-1:0] w_d_next;
    logic           w_wrap_next;

    // Next index, dwell count and wrap pulse, resolved in priority order:
    // load, direct hold, scan pause, dwell count, channel step.
    always_comb begin
        w_idx_next  = r_idx;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (i_load) begin
            // Load works in both modes and ignores i_en. Clearing the count
            // gives the loaded channel a full dwell when scanning.
            w_idx_next = i_sel;
            w_cnt_next = CNT_ZERO;
        end else if (!i_mode) begin
            // Direct mode parks the counter at zero so that switching into
            // scan mode starts with a full dwell on the current channel.
            w_cnt_next = CNT_ZERO;
        end else if (!i_en) begin
            // Paused: index and partial dwell both hold, so resuming
            // continues the dwell instead of restarting it.
            w_cnt_next = r_cnt;
        end else if (r_cnt != CNT_LAST) begin
            // The counter only ever takes values 0..DWELL-1, so "not last"
            // is the same as "below DWELL-1".
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            // Dwell complete. The N-bit add wraps 2^N-1 -> 0 on its own.
            w_cnt_next  = CNT_ZERO;
            w_idx_next  = r_idx + IDX_ONE;
            w_wrap_next = (r_idx == IDX_LAST);
        end
    end

    // Strobe decode. It uses the index value being written on this edge, so
    // o_d and o_idx always change together. The shift result is one-hot
    // by construction.
    always_comb begin
        w_d_next = D_ZERO;
        if (i_en) begin
            w_d_next = D_LSB << w_idx_next;
        end else begin
            w_d_next = D_ZERO;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx  <= {N{1'b0}};
            r_cnt  <= CNT_ZERO;
            r_d    <= D_ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_cnt  <= w_cnt_next;
            r_d    <= w_d_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign o_d    = r_d;
    assign o_idx  = r_idx;
    assign o_wrap = r_wrap;

endmodule
